// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two 2-entry source queues (adder, multiplier)
// feeding one registered broadcast word per cycle under round-robin arbitration.

module cdb_fifo #(
  parameter int W = 23
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         nonempty,
  output logic         ready
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   occ;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (push) mem[wp] <= din;
  end

  assign dout     = mem[rp];
  assign nonempty = (occ != 2'd0);
  assign ready    = ~occ[1];
endmodule

module cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          addValid,
  input  logic [TAG_W-1:0]              addTag,
  input  logic [REG_W-1:0]              addReg,
  input  logic [DATA_W-1:0]             addData,
  output logic                          addReady,
  input  logic                          mulValid,
  input  logic [TAG_W-1:0]              mulTag,
  input  logic [REG_W-1:0]              mulReg,
  input  logic [DATA_W-1:0]             mulData,
  output logic                          mulReady,
  output logic                          cdbValid,
  output logic [TAG_W+REG_W+DATA_W-1:0] cdbOut,
  output logic                          cdbErr
);
  localparam int W = TAG_W + REG_W + DATA_W;

  // Index 0 is the adder, index 1 the multiplier.
  logic [1:0]        srcValid, rdy, push, pop, nonempty, tagZero;
  logic [1:0][W-1:0] din, dout;
  logic              rr;

  assign srcValid = {mulValid, addValid};
  assign din[0]   = {addTag, addReg, addData};
  assign din[1]   = {mulTag, mulReg, mulData};
  assign tagZero  = {mulTag == '0, addTag == '0};
  assign push     = srcValid & rdy & ~tagZero;
  assign addReady = rdy[0];
  assign mulReady = rdy[1];

  for (genvar i = 0; i < 2; i++) begin : g_src
    cdb_fifo #(.W(W)) u_q (
      .Clock    (Clock),
      .Reset    (Reset),
      .push     (push[i]),
      .pop      (pop[i]),
      .din      (din[i]),
      .dout     (dout[i]),
      .nonempty (nonempty[i]),
      .ready    (rdy[i])
    );
  end

  // rr == 0 favours the adder when both queues hold a word.
  always_comb begin
    pop = nonempty;
    if (&nonempty) pop = rr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cdbValid <= 1'b0;
      cdbOut   <= '0;
      cdbErr   <= 1'b0;
      rr       <= 1'b0;
    end else begin
      cdbValid <= |pop;
      if (pop[1])      cdbOut <= dout[1];
      else if (pop[0]) cdbOut <= dout[0];
      cdbErr <= |(srcValid & rdy & tagZero);
      // Pointer moves to the loser only when there was contention.
      if (&nonempty) rr <= pop[0];
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        addValid = 1'b0, mulValid = 1'b0;
  logic [2:0]  addTag = '0, mulTag = '0;
  logic [3:0]  addReg = '0, mulReg = '0;
  logic [15:0] addData = '0, mulData = '0;
  logic        addReady, mulReady, cdbValid, cdbErr;
  logic [22:0] cdbOut;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.DATA_W(16), .TAG_W(3), .REG_W(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .addValid(addValid), .addTag(addTag), .addReg(addReg), .addData(addData), .addReady(addReady),
    .mulValid(mulValid), .mulTag(mulTag), .mulReg(mulReg), .mulData(mulData), .mulReady(mulReady),
    .cdbValid(cdbValid), .cdbOut(cdbOut), .cdbErr(cdbErr)
  );

  always #5 Clock = ~Clock;

  // Adder word k: tag 1, reg k, data 0x100+k. Multiplier word k: tag 5, reg 8+k, data 0x200+k.
  function automatic logic [22:0] aw(input int k);
    return {3'd1, 4'(k), 16'h0100 + 16'(k)};
  endfunction
  function automatic logic [22:0] mw(input int k);
    return {3'd5, 4'(8 + k), 16'h0200 + 16'(k)};
  endfunction

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic idle();
    addValid = 1'b0; mulValid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic drive_add(input int k);
    addValid = 1'b1; {addTag, addReg, addData} = aw(k);
  endtask
  task automatic drive_mul(input int k);
    mulValid = 1'b1; {mulTag, mulReg, mulData} = mw(k);
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    drive_add(0); drive_mul(0);
    #1;
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", cdbValid); end
    checks++; if (cdbOut !== 23'h0) begin errors++; $display("FAIL rst_out got %h want 0", cdbOut); end
    checks++; if (cdbErr !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", cdbErr); end
    checks++; if ({addReady, mulReady} !== 2'b11) begin errors++; $display("FAIL rst_ready got %b want 11", {addReady, mulReady}); end
    tick(); tick();
    checks++; if ({cdbValid, addReady, mulReady} !== 3'b011) begin errors++; $display("FAIL rst_hold got %b want 011", {cdbValid, addReady, mulReady}); end
    idle();
    Reset = 1'b0;
    tick(); tick();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL rst_ignored got %b want 0", cdbValid); end
  endtask

  task automatic test_single();
    do_reset();
    addValid = 1'b1; addTag = 3'd1; addReg = 4'd2; addData = 16'h0005;
    tick(); idle();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", cdbValid); end
    tick();
    checks++; if (cdbValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", cdbValid); end
    checks++; if (cdbOut !== 23'h120005) begin errors++; $display("FAIL single_out got %h want 120005", cdbOut); end
    tick();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", cdbValid); end
    checks++; if (cdbOut !== 23'h120005) begin errors++; $display("FAIL single_holdout got %h want 120005", cdbOut); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    addValid = 1'b1; addTag = 3'd2; addReg = 4'd1; addData = 16'h0010;
    mulValid = 1'b1; mulTag = 3'd4; mulReg = 4'd3; mulData = 16'h0020;
    tick(); idle(); tick();
    checks++; if ({cdbValid, cdbOut} !== {1'b1, 23'h210010}) begin errors++; $display("FAIL same_first got %b/%h want 1/210010", cdbValid, cdbOut); end
    tick();
    checks++; if ({cdbValid, cdbOut} !== {1'b1, 23'h430020}) begin errors++; $display("FAIL same_second got %b/%h want 1/430020", cdbValid, cdbOut); end
    tick();
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL same_done got %b want 0", cdbValid); end
  endtask

  task automatic test_backpressure();
    logic [22:0] exp [6];
    logic [22:0] got [8];
    int ai = 0, mi = 0, n = 0;
    bit sawFull = 0;
    exp[0] = {3'd1, 4'd0, 16'h0100}; exp[1] = {3'd5, 4'd8, 16'h0200};
    exp[2] = {3'd1, 4'd1, 16'h0101}; exp[3] = {3'd5, 4'd9, 16'h0201};
    exp[4] = {3'd1, 4'd2, 16'h0102}; exp[5] = {3'd1, 4'd3, 16'h0103};
    do_reset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      bit accA, accM;
      if (ai < 4) drive_add(ai); else addValid = 1'b0;
      if (mi < 2) drive_mul(mi); else mulValid = 1'b0;
      accA = addValid && addReady;
      accM = mulValid && mulReady;
      tick();
      if (accA) ai++;
      if (accM) mi++;
      if (!mulReady) sawFull = 1;
      if (cdbValid) begin
        if (n < 8) got[n] = cdbOut;
        n++;
      end
    end
    idle();
    checks++; if (sawFull !== 1'b1) begin errors++; $display("FAIL bp_mulready got never-low want low-at-2"); end
    checks++; if (n !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= n || got[i] !== exp[i]) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, (i < n) ? got[i] : 23'h0, exp[i]);
      end
    end
  endtask

  task automatic test_tag0();
    do_reset();
    addValid = 1'b1; addTag = 3'd0; addReg = 4'd7; addData = 16'h0077;
    tick(); idle();
    checks++; if (cdbErr !== 1'b1) begin errors++; $display("FAIL tag0_err got %b want 1", cdbErr); end
    checks++; if (cdbValid !== 1'b0) begin errors++; $display("FAIL tag0_valid got %b want 0", cdbValid); end
    tick();
    checks++; if ({cdbErr, cdbValid, addReady} !== 3'b001) begin errors++; $display("FAIL tag0_after got %b want 001", {cdbErr, cdbValid, addReady}); end
  endtask

  task automatic test_reset_mid();
    int ai = 0, mi = 0;
    bit stale = 0;
    do_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      bit accA, accM;
      drive_add(ai); drive_mul(mi);
      accA = addReady; accM = mulReady;
      tick();
      if (accA) ai++;
      if (accM) mi++;
    end
    checks++; if (addReady !== 1'b0) begin errors++; $display("FAIL mid_pre_full got %b want 0", addReady); end
    idle();
    Reset = 1'b1;
    #1;
    checks++; if ({cdbValid, addReady, mulReady} !== 3'b011) begin errors++; $display("FAIL mid_rst got %b want 011", {cdbValid, addReady, mulReady}); end
    checks++; if (cdbOut !== 23'h0) begin errors++; $display("FAIL mid_rst_out got %h want 0", cdbOut); end
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (cdbValid) stale = 1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale got broadcast want none"); end
  endtask

  task automatic test_back_to_back();
    int ai = 0, mi = 0;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      bit accA, accM;
      drive_add(ai); drive_mul(mi);
      accA = addReady; accM = mulReady;
      tick();
      if (accA) ai++;
      if (accM) mi++;
      if (cyc >= 1) begin
        int j;
        logic [22:0] e;
        j = cyc - 1;
        e = (j % 2 == 0) ? aw(j / 2) : mw(j / 2);
        checks++;
        if (cdbValid !== 1'b1 || cdbOut !== e) begin
          errors++; $display("FAIL b2b_cyc%0d got %b/%h want 1/%h", cyc, cdbValid, cdbOut, e);
        end
      end
    end
    idle();
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_backpressure();
    test_tag0();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of the broadcast data field.
REQ-002 Parameter TAG_W, default 3, sets the width of the reservation-station label; value 0 means "no producer".
REQ-003 Parameter REG_W, default 4, sets the width of the destination-register field.
REQ-004 Port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port addValid, input, 1 bit: the adder unit presents a result.
REQ-007 Port addTag / addReg / addData, inputs, TAG_W / REG_W / DATA_W bits: the adder's producing station label, destination register and result.
REQ-008 Port addReady, output, 1 bit: the adder queue accepts a word this cycle.
REQ-009 Port mulValid, input, 1 bit; ports mulTag / mulReg / mulData, inputs, TAG_W / REG_W / DATA_W bits; port mulReady, output, 1 bit: the same roles for the multiplier unit.
REQ-010 Port cdbValid, output, 1 bit: the CDB carries a valid broadcast this cycle.
REQ-011 Port cdbOut, output, TAG_W+REG_W+DATA_W bits: the broadcast word {tag, reg, data}, with the tag in the MSBs (default [22:20] tag, [19:16] reg, [15:0] data).
REQ-012 Port cdbErr, output, 1 bit: a one-cycle pulse when a word with tag 0 is discarded.

Function
REQ-013 Each source owns a 2-entry FIFO, occupancy 0..2.
REQ-014 The block asserts xReady exactly when the source's occupancy is below 2; xReady is derived from registered state only.
REQ-015 A word is accepted when xValid and xReady are both high at the rising edge; xValid without xReady has no effect, and the source holds its word.
REQ-016 An accepted word with tag 0 is not enqueued; the block pulses cdbErr high for the following cycle.
REQ-017 Each cycle, at most one FIFO head is popped and registered onto cdbOut, with cdbValid high in the next cycle.
REQ-018 Arbitration: if only one FIFO is non-empty, it wins.
REQ-019 If both FIFOs are non-empty, a round-robin pointer selects the winner, and the pointer then flips to the loser.
REQ-020 The round-robin pointer resets to favour the adder.
REQ-021 If neither FIFO is non-empty, cdbValid is low in the next cycle and cdbOut holds its previous value.
REQ-022 Minimum latency is 1 cycle: a word accepted into an empty FIFO with no competitor appears on the CDB in the following cycle.
REQ-023 A word accepted at edge N is eligible for arbitration at edge N+1, so it appears on the CDB at the earliest after edge N+1.
REQ-024 On a simultaneous push and pop of the same FIFO in one cycle, occupancy is unchanged and order is preserved (FIFO order).
REQ-025 A push is only possible when occupancy is below 2, so occupancy never exceeds 2 and a push is never lost.
REQ-026 Read and write pointers are 1 bit each and wrap modulo 2.
REQ-027 Per-source order is always preserved; cross-source order follows arbitration only.
REQ-028 cdbValid is high for exactly one cycle per broadcast word; each word is broadcast exactly once.
REQ-029 Both sources sustaining valid input yields alternating add, mul, add, mul words at full CDB throughput (one word per cycle).

Reset
REQ-030 While Reset is high, the block immediately forces cdbValid=0, cdbOut=0, cdbErr=0, both occupancies to 0, all pointers to 0, and the round-robin pointer to the adder.
REQ-031 While Reset is high, addReady=1 and mulReady=1; handshakes attempted during reset are ignored.
REQ-032 A reset asserted mid-operation discards all queued words; no partial broadcast is produced after Reset deasserts.
REQ-033 The first accepted word after reset appears on the CDB with latency per REQ-022.

Verification
REQ-034 Single adder word {tag 1, reg 2, data 0x0005} -> next cycle cdbValid=1, cdbOut={3'd1, 4'd2, 16'h0005}; the cycle after, cdbValid=0.
REQ-035 Same-cycle add {tag 2, reg 1, data 0x0010} and mul {tag 4, reg 3, data 0x0020} after reset -> adder word first, multiplier word second, in consecutive cycles.
REQ-036 Hold mulReady low by stalling with 2 mul words while add streams 4 words -> mulReady=0 at occupancy 2; all 6 words broadcast exactly once; per-source order intact; adder and multiplier alternate while both are queued.
REQ-037 Add word with tag 0 -> cdbErr=1 for one cycle; no cdbValid for that word; FIFO occupancy unchanged.
REQ-038 Queue 2 adder words, then assert Reset for one cycle mid-stream -> immediately cdbValid=0 and addReady=1; no stale word is broadcast afterwards.
REQ-039 Continuous valid input on both sources for 10 cycles -> cdbValid high every cycle from the second; adder and multiplier words alternate.
